// File: rtl/regfile_op_sequencer.sv
// Micro-sequencer for a 2-entry register file: accepts one register-transfer
// instruction per handshake, reads two operands through the async read ports,
// computes with a small ALU and writes the result back. One instruction in flight.
module regfile_op_sequencer #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] Read_Address_1,
    output logic [ADDR_W-1:0] Read_Address_2,
    input  logic [DATA_W-1:0] Read_Data_1,
    input  logic [DATA_W-1:0] Read_Data_2,
    output logic [ADDR_W-1:0] Write_Address,
    output logic [DATA_W-1:0] Write_Data,
    output logic              Write_Enable,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        EXEC  = 2'b10,
        WRITE = 2'b11
    } state_t;

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_AND  = 2'b11;

    state_t              state_q;
    state_t              next_state;
    logic                accept;

    // instruction fields latched at acceptance
    logic [1:0]          op_p0;
    logic [ADDR_W-1:0]   rd_p0;
    logic [DATA_W-1:0]   imm_p0;
    // operands sampled in READ
    logic [DATA_W-1:0]   op_a_p1;
    logic [DATA_W-1:0]   op_b_p1;
    // ALU outputs computed in EXEC
    logic [DATA_W-1:0]   res_p2;
    logic                carry_p2;

    // ALU: returns {carry/borrow, result}. The extra top bit of the widened
    // subtraction is set exactly when a < b, so it doubles as the borrow flag.
    function automatic logic [DATA_W:0] alu(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] imm
    );
        logic [DATA_W:0] r;
        case (op)
            OP_MOVI: r = {1'b0, imm};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            default: r = '0;
        endcase
        return r;
    endfunction

    // in_ready is registered so it stays low while reset is asserted
    assign accept        = (state_q == IDLE) && in_valid && in_ready;
    assign Write_Address = rd_p0;
    assign Write_Data    = res_p2;

    // State register and handshake-ready flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            in_ready <= 1'b0;
        end else begin
            state_q  <= next_state;
            in_ready <= (next_state == IDLE);
        end
    end

    // Next-state and write-port strobes
    always_comb begin
        next_state   = state_q;
        Write_Enable = 1'b0;
        done         = 1'b0;
        case (state_q)
            IDLE:  if (accept) next_state = READ;
            READ:  next_state = EXEC;
            EXEC:  next_state = WRITE;
            WRITE: begin
                Write_Enable = 1'b1;
                done         = 1'b1;
                next_state   = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Latch the instruction; read addresses hold rs1/rs2 until the next accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_p0          <= '0;
            rd_p0          <= '0;
            imm_p0         <= '0;
            Read_Address_1 <= '0;
            Read_Address_2 <= '0;
        end else if (accept) begin
            op_p0          <= in_op;
            rd_p0          <= in_rd;
            imm_p0         <= in_imm;
            Read_Address_1 <= in_rs1;
            Read_Address_2 <= in_rs2;
        end
    end

    // Sample operands from the combinational read ports at the end of READ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a_p1 <= '0;
            op_b_p1 <= '0;
        end else if (state_q == READ) begin
            op_a_p1 <= Read_Data_1;
            op_b_p1 <= Read_Data_2;
        end
    end

    // Register the ALU result and flag at the end of EXEC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_p2   <= '0;
            carry_p2 <= 1'b0;
        end else if (state_q == EXEC) begin
            {carry_p2, res_p2} <= alu(op_p0, op_a_p1, op_b_p1, imm_p0);
        end
    end

    // Publish result and flags on the WRITE edge; held until the next WRITE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
        end else if (state_q == WRITE) begin
            result <= res_p2;
            zero   <= (res_p2 == '0);
            carry  <= carry_p2;
        end
    end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 2-entry register file.
module tb_regfile_op_sequencer;

    localparam int DATA_W = 2;
    localparam int ADDR_W = 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [ADDR_W-1:0] in_rd;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] Read_Address_1;
    logic [ADDR_W-1:0] Read_Address_2;
    logic [DATA_W-1:0] Read_Data_1;
    logic [DATA_W-1:0] Read_Data_2;
    logic [ADDR_W-1:0] Write_Address;
    logic [DATA_W-1:0] Write_Data;
    logic              Write_Enable;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;

    logic [DATA_W-1:0] rf [2];

    int n_total = 0;
    int n_pass  = 0;

    regfile_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_rd          (in_rd),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .Read_Address_1 (Read_Address_1),
        .Read_Address_2 (Read_Address_2),
        .Read_Data_1    (Read_Data_1),
        .Read_Data_2    (Read_Data_2),
        .Write_Address  (Write_Address),
        .Write_Data     (Write_Data),
        .Write_Enable   (Write_Enable),
        .done           (done),
        .result         (result),
        .zero           (zero),
        .carry          (carry)
    );

    always #5 clk = ~clk;

    // Register file model: async read, sync write
    assign Read_Data_1 = rf[Read_Address_1];
    assign Read_Data_2 = rf[Read_Address_2];
    always @(posedge clk) begin
        if (Write_Enable) rf[Write_Address] <= Write_Data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one instruction at a negedge and follow it through all four states.
    task automatic run_instr(
        input string       name,
        input logic [1:0]  op,
        input logic        rd,
        input logic        rs1,
        input logic        rs2,
        input logic [1:0]  imm,
        input logic [1:0]  exp_res,
        input logic        exp_zero,
        input logic        exp_carry
    );
        int waited = 0;
        while (!in_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        @(negedge clk);                 // READ
        in_valid = 1'b0;
        check({name, "_ra1"}, Read_Address_1, rs1);
        check({name, "_ra2"}, Read_Address_2, rs2);
        check({name, "_ready_busy"}, in_ready, 0);
        @(negedge clk);                 // EXEC
        check({name, "_we_exec"}, Write_Enable, 0);
        @(negedge clk);                 // WRITE
        check({name, "_we"}, Write_Enable, 1);
        check({name, "_done"}, done, 1);
        check({name, "_wa"}, Write_Address, rd);
        check({name, "_wd"}, Write_Data, exp_res);
        @(negedge clk);                 // back in IDLE
        check({name, "_done_off"}, done, 0);
        check({name, "_result"}, result, exp_res);
        check({name, "_zero"}, zero, exp_zero);
        check({name, "_carry"}, carry, exp_carry);
        check({name, "_rf"}, rf[rd], exp_res);
        check({name, "_ready_idle"}, in_ready, 1);
    endtask

    initial begin
        int d1, d2, ndone, we_seen, done_seen;
        bit drop;

        reset = 1'b0; in_valid = 1'b0;
        in_op = 2'b00; in_rd = 1'b0; in_rs1 = 1'b0; in_rs2 = 1'b0; in_imm = 2'b00;

        // 1. reset for 2 cycles
        @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_we", Write_Enable, 0);
        check("rst_done", done, 0);
        check("rst_outs", {Read_Address_1, Read_Address_2, Write_Address, Write_Data, result, zero, carry}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);

        // 2. MOVI r0=01, MOVI r1=11
        run_instr("movi0", 2'b00, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0);
        run_instr("movi1", 2'b00, 1'b1, 1'b0, 1'b0, 2'b11, 2'b11, 1'b0, 1'b0);
        check("rf_r0_after_movi", rf[0], 2'b01);

        // 3. ADD r0 = r0 + r1 = 01 + 11 -> 00 carry
        run_instr("add", 2'b01, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1);

        // 4. SUB r1 = r0 - r1 = 00 - 11 -> 01 borrow; AND r0 = r1 & r1 = 01
        run_instr("sub", 2'b10, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1);
        run_instr("and", 2'b11, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0);

        // 5. MOVI r1=10 then MOVI r0=11 held valid while the first is in flight
        in_op = 2'b00; in_rd = 1'b1; in_imm = 2'b10; in_valid = 1'b1;
        @(negedge clk);
        in_rd = 1'b0; in_imm = 2'b11;
        d1 = -1; d2 = -1; ndone = 0; drop = 0;
        for (int c = 1; c < 14; c++) begin
            if (done) begin
                ndone++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 1) check("bb_ready_busy", in_ready, 0);
            if (drop) in_valid = 1'b0;
            if (in_ready && in_valid) drop = 1;
            @(negedge clk);
        end
        check("bb_done_count", ndone, 2);
        check("bb_first_done", d1, 3);
        check("bb_gap", d2 - d1, 4);
        check("bb_rf1", rf[1], 2'b10);
        check("bb_rf0", rf[0], 2'b11);

        // 6. ADD r1 = r0 + r1, reset asserted during EXEC
        in_op = 2'b01; in_rd = 1'b1; in_rs1 = 1'b0; in_rs2 = 1'b1; in_valid = 1'b1;
        @(negedge clk);                 // READ
        in_valid = 1'b0;
        @(negedge clk);                 // EXEC
        reset = 1'b0;
        #1;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_outs", {Write_Enable, done, result, zero, carry}, 0);
        we_seen = 0; done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) reset = 1'b1;
            if (Write_Enable) we_seen++;
            if (done) done_seen++;
        end
        check("mid_rst_no_we", we_seen, 0);
        check("mid_rst_no_done", done_seen, 0);
        check("mid_rst_rf1", rf[1], 2'b10);
        check("mid_rst_idle", in_ready, 1);

        // FSM still usable after the abandoned instruction
        run_instr("movi_post", 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #20000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
